hazard_scoreboard: RTL and testbench

Parametrised pipeline hazard unit for the RV32 core: a scoreboard of in-flight register writers that sits beside the decode stage, generates decode stall and flush, and selects operand forwarding sources. It replaces the fixed no-interlock timing of the current 5-stage core with configurable pipeline depth, result-ready points and redirect handling. Decode, ALU-input muxes and the PC stage consume its outputs.

---
 rtl/hazard_scoreboard_pkg.sv | 14 +
 rtl/hazard_match.sv | 29 ++
 rtl/hazard_scoreboard.sv | 72 +++++++
 tb/tb_hazard_scoreboard.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared scoreboard entry type, forward-select width helper and register-file select constant
package hazard_scoreboard_pkg;
  localparam int RA_W_MAX = 8;
  localparam int FWD_RF = 0;
  typedef struct packed {
    logic                valid;
    logic [RA_W_MAX-1:0] rd;
    logic                we;
    logic                load;
  } sb_entry_t;
  function automatic int fs_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/hazard_match.sv
// hazard_match: youngest in-flight writer of one source register; reports hit, readiness and its stage index
module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int RA_W    = 5,
  parameter int DEPTH   = 4,
  parameter int ALU_RDY = 2,
  parameter int LD_RDY  = 3,
  parameter int FS_W    = fs_width(DEPTH)
) (
  input  sb_entry_t [DEPTH:1] sb,
  input  logic [RA_W-1:0]     src,
  input  logic                used,
  output logic                hit,
  output logic                rdy,
  output logic [FS_W-1:0]     sel
);
  always_comb begin
    hit = 1'b0;
    rdy = 1'b0;
    sel = FS_W'(FWD_RF);
    for (int k = DEPTH; k >= 1; k--)
      if (sb[k].valid && sb[k].we && sb[k].rd == RA_W_MAX'(src) && src != '0 && used) begin
        hit = 1'b1;
        rdy = k >= (sb[k].load ? LD_RDY : ALU_RDY);
        sel = FS_W'(k);
      end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight writer scoreboard driving decode stall/flush, forward selects and a saturating stall counter; HAZARD_FWD_EN enables forwarding
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RA_W    = 5,
  parameter int DEPTH   = 4,
  parameter int ALU_RDY = 2,
  parameter int LD_RDY  = 3,
  parameter int FS_W    = fs_width(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_we,
  input  logic            id_load,
  input  logic            redirect,
  output logic            stall,
  output logic            flush,
  output logic [FS_W-1:0] fwd1_sel,
  output logic [FS_W-1:0] fwd2_sel,
  output logic [XLEN-1:0] stall_cnt
);
  sb_entry_t [DEPTH:1] sb_q, sb_d;
  sb_entry_t           ins;
  logic [XLEN-1:0]     stall_cnt_q, stall_cnt_d;
  logic                hit1, hit2, rdy1, rdy2, hazard;
  logic [FS_W-1:0]     sel1, sel2;

  hazard_match #(.RA_W(RA_W), .DEPTH(DEPTH), .ALU_RDY(ALU_RDY), .LD_RDY(LD_RDY), .FS_W(FS_W)) u_m1 (
    .sb(sb_q), .src(id_rs1), .used(id_rs1_used), .hit(hit1), .rdy(rdy1), .sel(sel1)
  );
  hazard_match #(.RA_W(RA_W), .DEPTH(DEPTH), .ALU_RDY(ALU_RDY), .LD_RDY(LD_RDY), .FS_W(FS_W)) u_m2 (
    .sb(sb_q), .src(id_rs2), .used(id_rs2_used), .hit(hit2), .rdy(rdy2), .sel(sel2)
  );

`ifdef HAZARD_FWD_EN
  always_comb begin
    hazard   = (hit1 && !rdy1) || (hit2 && !rdy2);
    fwd1_sel = hit1 && rdy1 ? sel1 : FS_W'(FWD_RF);
    fwd2_sel = hit2 && rdy2 ? sel2 : FS_W'(FWD_RF);
  end
`else
  logic unused_fwd;
  always_comb begin
    hazard     = hit1 || hit2;
    fwd1_sel   = FS_W'(FWD_RF);
    fwd2_sel   = FS_W'(FWD_RF);
    unused_fwd = ^{rdy1, rdy2, sel1, sel2};
  end
`endif

  always_comb begin
    stall       = id_valid && !redirect && hazard;
    flush       = redirect;
    ins         = id_valid && !stall && !redirect ? sb_entry_t'{1'b1, RA_W_MAX'(id_rd), id_we, id_load} : '0;
    sb_d        = {sb_q[DEPTH-1:1], ins};
    stall_cnt_d = stall && !(&stall_cnt_q) ? stall_cnt_q + XLEN'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    sb_q        <= rst ? '0 : sb_d;
    stall_cnt_q <= rst ? '0 : stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and random checks of hazard_scoreboard against an issue-time reference model
module tb_hazard_scoreboard;
  localparam int XLEN = 4, RA_W = 5, DEPTH = 4, ALU_RDY = 2, LD_RDY = 3, FS_W = 3;
  localparam int SAT = (1 << XLEN) - 1;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_we = 1'b0, id_load = 1'b0, redirect = 1'b0;
  logic [RA_W-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic stall, flush;
  logic [FS_W-1:0] fwd1_sel, fwd2_sel;
  logic [XLEN-1:0] stall_cnt;

  hazard_scoreboard #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .ALU_RDY(ALU_RDY), .LD_RDY(LD_RDY), .FS_W(FS_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_we(id_we),
    .id_load(id_load), .redirect(redirect), .stall(stall), .flush(flush),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int rd; bit we; bit load; int t;} instr_t;
  instr_t fl[$];
  int cyc = 0, exp_cnt = 0, pass_cnt = 0, total = 0;
  logic o_stall, o_flush;
  logic [FS_W-1:0] o_f1, o_f2;

  function automatic void youngest(input int s, input bit used, output bit hit, output bit rdy, output int age);
    hit = 0;
    rdy = 0;
    age = 0;
    if (!used || s == 0) return;
    foreach (fl[i]) begin
      int a = cyc - fl[i].t;
      if (a >= 1 && a <= DEPTH && fl[i].we && fl[i].rd == s && (!hit || a < age)) begin
        hit = 1;
        age = a;
        rdy = a >= (fl[i].load ? LD_RDY : ALU_RDY);
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                      input int rd, input bit we, input bit ld, input bit rdr);
    bit h1, k1, h2, k2, es;
    int a1, a2;
    id_valid = v; id_rs1 = r1[RA_W-1:0]; id_rs2 = r2[RA_W-1:0];
    id_rs1_used = u1; id_rs2_used = u2; id_rd = rd[RA_W-1:0];
    id_we = we; id_load = ld; redirect = rdr;
    #4;
    es = 0;
    if (!rst) begin
      youngest(r1, u1, h1, k1, a1);
      youngest(r2, u2, h2, k2, a2);
      es = v && !rdr && (FWD ? ((h1 && !k1) || (h2 && !k2)) : (h1 || h2));
      chk("stall", stall, es);
      chk("flush", flush, rdr);
      chk("stall_cnt", stall_cnt, exp_cnt);
      if (!es) begin
        chk("fwd1", fwd1_sel, FWD && h1 && k1 ? a1 : 0);
        chk("fwd2", fwd2_sel, FWD && h2 && k2 ? a2 : 0);
      end
      o_stall = stall; o_flush = flush; o_f1 = fwd1_sel; o_f2 = fwd2_sel;
    end
    @(posedge clk);
    if (rst) begin
      fl.delete();
      exp_cnt = 0;
    end else begin
      if (es && exp_cnt < SAT) exp_cnt++;
      if (v && !es && !rdr) fl.push_back('{rd, we, ld, cyc});
    end
    cyc++;
    while (fl.size() > 0 && cyc - fl[0].t > DEPTH) void'(fl.pop_front());
    #1;
  endtask

  task automatic bub();
    tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    repeat (DEPTH + 1) bub();
  endtask

  task automatic rst_pulse();
    rst = 1;
    tick(1, 5, 5, 1, 1, 5, 1, 0, 0);
    tick(1, 5, 5, 1, 1, 5, 1, 1, 0);
    rst = 0;
  endtask

  task automatic load_use(output int n);
    tick(1, 0, 0, 0, 0, 7, 1, 1, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1, 7, 7, 1, 1, 8, 1, 0, 0);
      if (!o_stall) break;
      n++;
    end
  endtask

  initial begin
    int n;
    bit hold;
    int r1, r2, rd;
    bit v, u1, u2, we, ld, rdr;
    rst_pulse();
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_stall", stall, 0);
    tick(1, 5, 5, 1, 1, 6, 1, 0, 0);
    chk("rst_fwd1", o_f1, 0);
    drain();

    tick(1, 1, 2, 1, 1, 5, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1, 5, 1, 1, 1, 6, 1, 0, 0);
      if (!o_stall) break;
      n++;
    end
    chk("alu_stalls", n, FWD ? 1 : 4);
    chk("alu_fwd1", o_f1, FWD ? 2 : 0);
    chk("alu_fwd2", o_f2, 0);

    drain();
    rst_pulse();
    load_use(n);
    chk("lu_stalls", n, FWD ? 2 : 4);
    chk("lu_fwd1", o_f1, FWD ? 3 : 0);
    chk("lu_fwd2", o_f2, FWD ? 3 : 0);
    chk("lu_cnt", stall_cnt, FWD ? 2 : 4);

    drain();
    tick(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick(1, 7, 0, 1, 0, 8, 1, 0, 0);
    chk("rd_pre_stall", o_stall, 1);
    tick(1, 7, 0, 1, 0, 8, 1, 0, 1);
    chk("rd_flush", o_flush, 1);
    chk("rd_stall", o_stall, 0);
    tick(1, 8, 0, 1, 0, 9, 1, 0, 0);
    chk("rd_bubble", o_stall, 0);

    drain();
    tick(1, 0, 0, 0, 0, 7, 1, 1, 0);
    tick(1, 7, 0, 1, 0, 8, 1, 0, 0);
    rst = 1;
    tick(1, 7, 0, 1, 0, 8, 1, 0, 0);
    rst = 0;
    tick(1, 7, 0, 1, 0, 8, 1, 0, 0);
    chk("rst_mid_stall", o_stall, 0);

    drain();
    tick(1, 1, 1, 1, 1, 0, 1, 0, 0);
    tick(1, 0, 0, 1, 1, 3, 1, 0, 0);
    chk("x0_stall", o_stall, 0);
    chk("x0_fwd1", o_f1, 0);
    chk("x0_fwd2", o_f2, 0);

    rst_pulse();
    repeat (8) begin
      load_use(n);
      drain();
    end
    chk("sat_cnt", stall_cnt, SAT);
    load_use(n);
    chk("sat_hold", stall_cnt, SAT);

    hold = 0;
    {r1, r2, rd} = '0;
    {v, u1, u2, we, ld} = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        v = $urandom_range(0, 9) < 8;
        r1 = $urandom_range(0, 3);
        r2 = $urandom_range(0, 3);
        rd = $urandom_range(0, 3);
        u1 = $urandom_range(0, 1);
        u2 = $urandom_range(0, 1);
        we = $urandom_range(0, 3) != 0;
        ld = $urandom_range(0, 2) == 0;
      end
      rdr = $urandom_range(0, 9) == 0;
      rst = $urandom_range(0, 99) == 0;
      tick(v, r1, r2, u1, u2, rd, we, ld, rdr);
      hold = !rst && !rdr && o_stall;
      rst = 0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
